// File: rtl/operand_capture_pkg.sv
// Shared definitions for the divider front end: capture FSM states and timing defaults.
// The debounce default is also used by the display refresh divider.
package operand_capture_pkg;

  // 10 ms at 100 MHz
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1000000;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StIssue    = 3'd1,
    StWaitBusy = 3'd2,
    StWaitDone = 3'd3,
    StErr      = 3'd4
  } state_e;

  // States in which a new press is accepted.
  function automatic logic accepts_press(input state_e state);
    return (state == StIdle) || (state == StErr);
  endfunction

endpackage

// File: rtl/operand_capture_if.sv
// Button/switch inputs, divider-core handshake and status outputs of the operand capture block.
interface operand_capture_if #(
  parameter int unsigned WIDTH = 8
);

  logic             btn_start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             start_o;
  logic [WIDTH-1:0] x_o;
  logic [WIDTH-1:0] y_o;
  logic             ready;
  logic             done;
  logic             div_zero;
  logic             timeout;

  // Environment side: drives the raw inputs and the core busy flag.
  modport master (
    output btn_start, x, y, busy,
    input  start_o, x_o, y_o, ready, done, div_zero, timeout
  );

  // Capture block side.
  modport slave (
    input  btn_start, x, y, busy,
    output start_o, x_o, y_o, ready, done, div_zero, timeout
  );

endinterface

// File: rtl/operand_capture_btn_debounce.sv
// Two-flop synchroniser and counter-based debouncer for the start button.
// Emits a one-cycle pulse on each accepted rising level change.
module operand_capture_btn_debounce
  import operand_capture_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync_q;
  logic            level_q, level_d;
  logic            rise_q;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;

  // Counter runs only while the synced input disagrees with the accepted level;
  // any agreement restarts it, so short bounces never reach the threshold.
  always_comb begin
    cnt_inc = cnt_q + CntW'(1);
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_inc == CntW'(DEBOUNCE_CYCLES)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/operand_capture.sv
// Divider front end: synchronises operands, debounces the start button, issues a start
// pulse with latched operands and tracks the core busy handshake to completion.
module operand_capture
  import operand_capture_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned BUSY_TIMEOUT    = 16
) (
  input logic              clk,
  input logic              rst,
  operand_capture_if.slave bus
);

  localparam int unsigned TmrW = $clog2(BUSY_TIMEOUT + 1);

  logic             press;
  logic [WIDTH-1:0] x_meta_q, x_sync_q;
  logic [WIDTH-1:0] y_meta_q, y_sync_q;

  state_e           state_q, state_d;
  logic [TmrW-1:0]  timer_q, timer_d, timer_inc;
  logic [WIDTH-1:0] x_o_q, x_o_d;
  logic [WIDTH-1:0] y_o_q, y_o_d;
  logic             div_zero_q, div_zero_d;
  logic             timeout_q, timeout_d;
  logic             done_q, done_d;

  operand_capture_btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk (clk),
    .rst (rst),
    .btn (bus.btn_start),
    .rise(press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      x_meta_q <= '0;
      x_sync_q <= '0;
      y_meta_q <= '0;
      y_sync_q <= '0;
    end else begin
      x_meta_q <= bus.x;
      x_sync_q <= x_meta_q;
      y_meta_q <= bus.y;
      y_sync_q <= y_meta_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    x_o_d      = x_o_q;
    y_o_d      = y_o_q;
    div_zero_d = div_zero_q;
    timeout_d  = timeout_q;
    done_d     = 1'b0;
    timer_inc  = timer_q + TmrW'(1);

    unique case (state_q)
      StIdle, StErr: begin
        if (press) begin
          div_zero_d = 1'b0;
          timeout_d  = 1'b0;
          // A zero divisor is rejected before issue; the previous operands stay latched.
          if (y_sync_q == '0) begin
            div_zero_d = 1'b1;
            state_d    = StErr;
          end else begin
            x_o_d   = x_sync_q;
            y_o_d   = y_sync_q;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (bus.busy) begin
          state_d = StWaitDone;
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TmrW'(BUSY_TIMEOUT)) begin
            timeout_d = 1'b1;
            state_d   = StIdle;
          end
        end
      end
      StWaitDone: begin
        if (!bus.busy) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      x_o_q      <= '0;
      y_o_q      <= '0;
      div_zero_q <= 1'b0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      x_o_q      <= x_o_d;
      y_o_q      <= y_o_d;
      div_zero_q <= div_zero_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
    end
  end

  assign bus.start_o  = (state_q == StIssue);
  assign bus.ready    = accepts_press(state_q);
  assign bus.x_o      = x_o_q;
  assign bus.y_o      = y_o_q;
  assign bus.done     = done_q;
  assign bus.div_zero = div_zero_q;
  assign bus.timeout  = timeout_q;

endmodule
